// File: rtl/demux_1_to_10_collector.sv
// Serial-to-parallel frame collector: ten DATA_WIDTH words are steered into out0..out9, then held until acknowledged.
// Optional synchronous frame discard via the flush port when DEMUX_FLUSH_EN is defined.
module demux_1_to_10_collector #(
    parameter int DATA_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out0,
    output logic [DATA_WIDTH-1:0] out1,
    output logic [DATA_WIDTH-1:0] out2,
    output logic [DATA_WIDTH-1:0] out3,
    output logic [DATA_WIDTH-1:0] out4,
    output logic [DATA_WIDTH-1:0] out5,
    output logic [DATA_WIDTH-1:0] out6,
    output logic [DATA_WIDTH-1:0] out7,
    output logic [DATA_WIDTH-1:0] out8,
    output logic [DATA_WIDTH-1:0] out9,
    output logic [3:0]            wr_sel,
    output logic                  frame_valid,
    input  logic                  frame_ready
`ifdef DEMUX_FLUSH_EN
    ,
    input  logic                  flush
`endif
);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    localparam logic [3:0] LAST_SLOT = 4'd10;

    state_t                state_q;
    logic [3:0]            wr_sel_q;
    logic                  in_ready_q;
    logic                  frame_valid_q;
    logic                  flush_w;
    logic [DATA_WIDTH-1:0] slot_w [10];

`ifdef DEMUX_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    // Handshake flags are registered alongside the state so no input reaches an output combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= FILL;
            wr_sel_q      <= 4'd1;
            in_ready_q    <= 1'b1;
            frame_valid_q <= 1'b0;
        end else if (flush_w) begin
            state_q       <= FILL;
            wr_sel_q      <= 4'd1;
            in_ready_q    <= 1'b1;
            frame_valid_q <= 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    if (in_valid) begin
                        if (wr_sel_q == LAST_SLOT) begin
                            state_q       <= FULL;
                            wr_sel_q      <= 4'd0;
                            in_ready_q    <= 1'b0;
                            frame_valid_q <= 1'b1;
                        end else begin
                            wr_sel_q <= wr_sel_q + 4'd1;
                        end
                    end
                end
                FULL: begin
                    if (frame_ready) begin
                        state_q       <= FILL;
                        wr_sel_q      <= 4'd1;
                        in_ready_q    <= 1'b1;
                        frame_valid_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 10; gi++) begin : g_slot
            logic [DATA_WIDTH-1:0] slot_q;
            logic                  wr_en;

            // Slot gi+1 maps to out[gi]; wr_sel is 0 in FULL so no slot can match there.
            assign wr_en = in_ready_q & in_valid & (wr_sel_q == 4'(gi + 1));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    slot_q <= '0;
                end else if (flush_w) begin
                    slot_q <= '0;
                end else if (wr_en) begin
                    slot_q <= in_data;
                end
            end

            assign slot_w[gi] = slot_q;
        end
    endgenerate

    assign out0        = slot_w[0];
    assign out1        = slot_w[1];
    assign out2        = slot_w[2];
    assign out3        = slot_w[3];
    assign out4        = slot_w[4];
    assign out5        = slot_w[5];
    assign out6        = slot_w[6];
    assign out7        = slot_w[7];
    assign out8        = slot_w[8];
    assign out9        = slot_w[9];
    assign wr_sel      = wr_sel_q;
    assign in_ready    = in_ready_q;
    assign frame_valid = frame_valid_q;

endmodule

// File: tb/tb_demux_1_to_10_collector.sv
// Randomized self-checking bench for demux_1_to_10_collector against a word-count/frame-array model.
// Define DEMUX_FLUSH_EN for both files to exercise the flush scenarios.
module tb_demux_1_to_10_collector;

    localparam int DW = 24;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_w [10];
    logic [3:0]    wr_sel;
    logic          frame_valid;
    logic          frame_ready;
    logic          flush;

    int checks = 0;
    int errors = 0;

    // Model: words held in the current frame, whether the frame is complete, and the visible registers.
    int            m_cnt;
    bit            m_full;
    logic [DW-1:0] m_out [10];

    always #5 clk = ~clk;

    demux_1_to_10_collector #(.DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out0        (out_w[0]),
        .out1        (out_w[1]),
        .out2        (out_w[2]),
        .out3        (out_w[3]),
        .out4        (out_w[4]),
        .out5        (out_w[5]),
        .out6        (out_w[6]),
        .out7        (out_w[7]),
        .out8        (out_w[8]),
        .out9        (out_w[9]),
        .wr_sel      (wr_sel),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready)
`ifdef DEMUX_FLUSH_EN
        ,
        .flush       (flush)
`endif
    );

    function automatic logic [3:0] exp_wr_sel();
        return m_full ? 4'd0 : 4'(m_cnt + 1);
    endfunction

    task automatic model_reset();
        m_cnt  = 0;
        m_full = 1'b0;
        for (int i = 0; i < 10; i++) m_out[i] = '0;
    endtask

    // Drive one cycle, apply the frame rules to the model at the edge, return 1 ns after the edge.
    task automatic drive_cycle(input logic v, input logic [DW-1:0] d, input logic fr, input logic fl);
        in_valid    = v;
        in_data     = d;
        frame_ready = fr;
        flush       = fl;
        @(posedge clk);
        if (fl) begin
            model_reset();
        end else if (m_full) begin
            if (fr) begin
                m_full = 1'b0;
                m_cnt  = 0;
            end
        end else if (v) begin
            m_out[m_cnt] = d;
            m_cnt++;
            if (m_cnt == 10) m_full = 1'b1;
        end
        #1;
    endtask

    task automatic test_reset();
        in_valid = 0; in_data = '0; frame_ready = 0; flush = 0;
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
        checks++;
        if (wr_sel !== 4'd1) begin errors++; $display("FAIL reset_wr_sel got %0d want 1", wr_sel); end
        checks++;
        if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_frame_valid got %0b want 0", frame_valid); end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (out_w[i] !== '0) begin errors++; $display("FAIL reset_out%0d got %06h want 000000", i, out_w[i]); end
        end
        $display("reset: in_ready=%0b wr_sel=%0d frame_valid=%0b", in_ready, wr_sel, frame_valid);
    endtask

    task automatic test_stream();
        for (int k = 0; k < 10; k++) begin
            drive_cycle(1'b1, DW'(10 + k), 1'b0, 1'b0);
            checks++;
            if (out_w[k] !== DW'(10 + k)) begin
                errors++; $display("FAIL stream_out%0d got %06h want %06h", k, out_w[k], DW'(10 + k));
            end
            checks++;
            if (wr_sel !== exp_wr_sel()) begin
                errors++; $display("FAIL stream_wr_sel got %0d want %0d", wr_sel, exp_wr_sel());
            end
            $display("stream accept %0d: data=%06h wr_sel=%0d", k, 10 + k, wr_sel);
        end
        checks++;
        if (frame_valid !== 1'b1 || in_ready !== 1'b0 || wr_sel !== 4'd0) begin
            errors++;
            $display("FAIL stream_full got fv=%0b rdy=%0b sel=%0d want fv=1 rdy=0 sel=0", frame_valid, in_ready, wr_sel);
        end
        for (int c = 0; c < 20; c++) begin
            drive_cycle(1'b1, DW'($urandom), 1'b0, 1'b0);
            for (int i = 0; i < 10; i++) begin
                checks++;
                if (out_w[i] !== DW'(10 + i)) begin
                    errors++; $display("FAIL hold_out%0d cyc %0d got %06h want %06h", i, c, out_w[i], DW'(10 + i));
                end
            end
            checks++;
            if (frame_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++; $display("FAIL hold_flags cyc %0d got fv=%0b rdy=%0b want fv=1 rdy=0", c, frame_valid, in_ready);
            end
        end
        $display("stream: frame held 20 cycles, frame_valid=%0b", frame_valid);
    endtask

    task automatic test_back_to_back();
        drive_cycle(1'b0, '0, 1'b1, 1'b0);
        checks++;
        if (in_ready !== 1'b1 || wr_sel !== 4'd1 || frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL release got rdy=%0b sel=%0d fv=%0b want rdy=1 sel=1 fv=0", in_ready, wr_sel, frame_valid);
        end
        for (int k = 0; k < 10; k++) drive_cycle(1'b1, 24'hFFFFFF, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (out_w[i] !== 24'hFFFFFF) begin errors++; $display("FAIL ones_out%0d got %06h want ffffff", i, out_w[i]); end
        end
        checks++;
        if (frame_valid !== 1'b1) begin errors++; $display("FAIL ones_frame_valid got %0b want 1", frame_valid); end
        $display("back_to_back: second frame all ffffff, frame_valid=%0b", frame_valid);
    endtask

    task automatic test_gapped();
        int cyc;
        drive_cycle(1'b0, '0, 1'b1, 1'b0);
        cyc = 0;
        while (!m_full && cyc < 200) begin
            drive_cycle(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)), 1'b0);
            checks++;
            if (wr_sel !== exp_wr_sel() || frame_valid !== m_full) begin
                errors++;
                $display("FAIL gapped_cyc%0d got sel=%0d fv=%0b want sel=%0d fv=%0b", cyc, wr_sel, frame_valid, exp_wr_sel(), m_full);
            end
            cyc++;
        end
        checks++;
        if (!m_full) begin errors++; $display("FAIL gapped_timeout got accepts=%0d want 10", m_cnt); end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (out_w[i] !== m_out[i]) begin errors++; $display("FAIL gapped_out%0d got %06h want %06h", i, out_w[i], m_out[i]); end
        end
        $display("gapped: frame complete after %0d cycles", cyc);
    endtask

    task automatic test_reset_mid();
        drive_cycle(1'b0, '0, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) drive_cycle(1'b1, DW'($urandom), 1'b0, 1'b0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (in_ready !== 1'b1 || wr_sel !== 4'd1 || frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got rdy=%0b sel=%0d fv=%0b want rdy=1 sel=1 fv=0", in_ready, wr_sel, frame_valid);
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (out_w[i] !== '0) begin errors++; $display("FAIL async_reset_out%0d got %06h want 000000", i, out_w[i]); end
        end
        @(posedge clk); #1 rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) drive_cycle(1'b1, DW'(k), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (out_w[i] !== DW'(i + 1)) begin errors++; $display("FAIL post_reset_out%0d got %06h want %06h", i, out_w[i], DW'(i + 1)); end
        end
        checks++;
        if (frame_valid !== 1'b1) begin errors++; $display("FAIL post_reset_frame_valid got %0b want 1", frame_valid); end
        $display("reset_mid: partial frame dropped, frame 1..10 collected");
    endtask

`ifdef DEMUX_FLUSH_EN
    task automatic test_flush();
        drive_cycle(1'b0, '0, 1'b1, 1'b0);
        for (int k = 0; k < 7; k++) drive_cycle(1'b1, DW'($urandom), 1'b0, 1'b0);
        drive_cycle(1'b1, 24'hABCDEF, 1'b0, 1'b1);
        checks++;
        if (wr_sel !== 4'd1 || in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_fill got sel=%0d rdy=%0b want sel=1 rdy=1", wr_sel, in_ready);
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (out_w[i] !== '0) begin errors++; $display("FAIL flush_fill_out%0d got %06h want 000000", i, out_w[i]); end
        end
        for (int k = 0; k < 10; k++) drive_cycle(1'b1, DW'($urandom), 1'b0, 1'b0);
        drive_cycle(1'b0, '0, 1'b1, 1'b1);
        checks++;
        if (frame_valid !== 1'b0 || in_ready !== 1'b1 || wr_sel !== 4'd1) begin
            errors++;
            $display("FAIL flush_full got fv=%0b rdy=%0b sel=%0d want fv=0 rdy=1 sel=1", frame_valid, in_ready, wr_sel);
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (out_w[i] !== '0) begin errors++; $display("FAIL flush_full_out%0d got %06h want 000000", i, out_w[i]); end
        end
        $display("flush: partial and full frames discarded");
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_back_to_back();
        test_gapped();
        test_reset_mid();
`ifdef DEMUX_FLUSH_EN
        test_flush();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux_1_to_10_collector.md
# demux_1_to_10_collector

- Streaming 1-to-10 demultiplexer and frame buffer for the softmax datapath.
- Accepts DATA_WIDTH-bit words serially over a valid/ready handshake and steers each into one of ten output registers using the slot encoding of the softmax select path: slot 1 → out0 … slot 10 → out9, slot 0 → none.
- Once all ten slots are written, presents the complete frame in parallel and holds it until the consumer acknowledges.

## Interface
- DATA_WIDTH, 24, width of each data word and each output register
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_data  input  DATA_WIDTH  incoming word
- in_valid  input  1  in_data is valid this cycle
- in_ready  output  1  block accepts a word this cycle
- out0 … out9  output  DATA_WIDTH each  frame registers; outN holds the word written in slot N+1
- wr_sel  output  4  slot the next accepted word goes to (1..10); 0 when the frame is full
- frame_valid  output  1  all ten registers hold the current frame
- frame_ready  input  1  consumer takes the frame
- flush  input  1  synchronous frame discard (present only with DEMUX_FLUSH_EN)

## Operation
- Two states: FILL and FULL. Reset state is FILL.
- **FILL**
  - in_ready = 1; frame_valid = 0; wr_sel holds the current slot, 1..10.
  - A word is accepted when in_valid & in_ready are high at a rising edge. It is written to out[wr_sel-1], then wr_sel increments.
  - Accept with wr_sel = 10: write out9, set wr_sel = 0, go to FULL.
  - in_valid low: nothing changes.
- **FULL**
  - in_ready = 0; frame_valid = 1; wr_sel = 0; out0..out9 are stable.
  - frame_valid & frame_ready at a rising edge: go to FILL with wr_sel = 1.
- Registers are not cleared between frames. In FILL, slots not yet rewritten keep the previous frame's values. Consumers must sample only while frame_valid = 1.
- No width arithmetic. Words are stored bit-exact.
- in_valid in FULL is ignored. The upstream producer must hold its word, per the handshake.
- wr_sel never takes values 11..15. Decoding those values is a verification error.

## Timing
- Reset values, asynchronous, applied immediately on rst_n low:
  - state = FILL, wr_sel = 1, in_ready = 1, frame_valid = 0
  - out0..out9 = 0
- in_ready and frame_valid decode from registered state only. There is no combinational path from in_valid or frame_ready to any output.
- Write latency: a word accepted at edge N is visible on its outN after edge N.
- Frame latency: the 10th accept at edge N drives frame_valid = 1 after edge N.
- Release: a frame handshake at edge M drives in_ready = 1 and wr_sel = 1 after edge M. The first new word can be accepted at edge M+1. There is no same-cycle bypass.
- Throughput: at most one frame per 11 cycles.
- Reset mid-frame: the partial frame is dropped and all values return to reset values.

## Configuration
- Macro: DEMUX_FLUSH_EN.
- **Defined:** the flush port exists. flush = 1 at a rising edge, in either state:
  - go to FILL, wr_sel = 1, frame_valid = 0
  - out0..out9 = 0
  - any simultaneous input handshake or frame handshake is ignored
  - flush has priority over all other events
- **Undefined:** no flush port. The only way to discard a partial frame is rst_n.

## Test plan
- Reset → after rst_n deasserts: in_ready = 1, wr_sel = 1, frame_valid = 0, all outN = 0.
- Stream 10..19 (0x00000A..0x000013) back-to-back with frame_ready = 0:
  - out0 = 0x00000A … out9 = 0x000013
  - frame_valid = 1 one cycle after the 10th accept; in_ready = 0; wr_sel = 0
  - outputs are stable for 20 more cycles with in_valid held at 1
- Pulse frame_ready for 1 cycle in FULL → next cycle in_ready = 1, wr_sel = 1. A second frame 0xFFFFFF × 10 then completes with all outN = 0xFFFFFF.
- Gapped input, with in_valid toggling randomly over 40 cycles → wr_sel advances only on handshakes; frame completes after exactly 10 accepts with the correct order.
- Assert rst_n low after 5 accepts → outputs immediately return to reset values. A following full frame of 1..10 fills out0 = 1 … out9 = 10.
- DEMUX_FLUSH_EN:
  - flush after 7 accepts, coincident with in_valid → wr_sel = 1, all outN = 0, and the coincident word is not written.
  - flush in FULL together with frame_ready → FILL, all outN = 0.
